// File: rtl/mpadd_seq_112_pkg.sv
// Shared types and constants for the word-serial multi-precision add/subtract sequencer.
package mpadd_seq_112_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Subtraction adds the ones' complement of B; the +1 comes in through the initial carry.
  function automatic logic [WORD_W-1:0] eff_b(input logic [WORD_W-1:0] b, input logic op);
    return (op == OP_ADD) ? b : ~b;
  endfunction

endpackage

// File: rtl/add32_112.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with the group carries chained.
module add32_112
  import mpadd_seq_112_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              c0,
  output logic [WORD_W-1:0] sum_c,
  output logic              c32_c
);

  localparam int unsigned GRP_W = 4;
  localparam int unsigned N_GRP = WORD_W / GRP_W;

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [WORD_W:0]   c;
  logic [N_GRP-1:0]  gg;
  logic [N_GRP-1:0]  gp;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    c  = '0;
    c[0] = c0;
    for (int i = 0; i < int'(N_GRP); i++) begin
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
      // In-group carries all look ahead from the group's carry-in.
      c[4*i+1] = g[4*i] | (p[4*i] & c[4*i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & c[4*i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & c[4*i]);
      c[4*i+4] = gg[i] | (gp[i] & c[4*i]);
    end
    sum_c = p ^ c[WORD_W-1:0];
    c32_c = c[WORD_W];
  end

endmodule

// File: rtl/mpadd_seq_112.sv
// Word-serial multi-precision add/subtract sequencer, LS word first, carry chained through a register.
// Optional signed-overflow output `ovf` is built when MPADD_OVF_DETECT_EN is defined.
module mpadd_seq_112
  import mpadd_seq_112_pkg::*;
#(
  parameter int unsigned WORDS = 4,
  parameter int unsigned IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sub,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_word,
  input  logic [WORD_W-1:0] b_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] s_word,
  output logic              out_last,
  output logic              carry_out,
  output logic              busy,
  output logic              done
`ifdef MPADD_OVF_DETECT_EN
  ,
  output logic              ovf
`endif
);

  state_e            state;
  state_e            next_state;
  logic              sub_q;
  logic              carry_q;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] b_eff;
  logic [WORD_W-1:0] sum;
  logic              c32;
  logic              in_fire;
  logic              out_fire;
  logic              last_c;
  logic              start_c;

  assign b_eff    = eff_b(b_word, sub_q);
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_c   = (idx == IDX_W'(WORDS - 1));
  assign start_c  = (state == IDLE) && start;

  add32_112 u_add (
    .a     (a_word),
    .b     (b_eff),
    .c0    (carry_q),
    .sum_c (sum),
    .c32_c (c32)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (in_fire && last_c) next_state = DRAIN;
      DRAIN:   if (out_fire && out_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status flags are registered off the next state so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      done <= (next_state == DONE);
    end
  end

  // Datapath: op latch, index, carry chain and the single output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q     <= OP_ADD;
      carry_q   <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      s_word    <= '0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
    end else if (start_c) begin
      sub_q     <= sub;
      carry_q   <= (sub == OP_SUB);
      idx       <= '0;
      carry_out <= 1'b0;
    end else if (in_fire) begin
      s_word    <= sum;
      carry_q   <= c32;
      out_valid <= 1'b1;
      out_last  <= last_c;
      // Holding the index on the last word keeps it from wrapping when WORDS == 2**IDX_W.
      idx       <= last_c ? idx : idx + IDX_W'(1);
      if (last_c) carry_out <= c32;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MPADD_OVF_DETECT_EN
  logic ovf_c;

  // Signed overflow: operand signs agree and the result sign differs from them.
  assign ovf_c = (a_word[WORD_W-1] ~^ b_eff[WORD_W-1]) & (sum[WORD_W-1] ^ a_word[WORD_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovf <= 1'b0;
    else if (start_c)            ovf <= 1'b0;
    else if (in_fire && last_c)  ovf <= ovf_c;
  end
`endif

endmodule

// File: tb/tb_mpadd_seq_112.sv
// Directed bench for mpadd_seq_112: hand-computed 128-bit add/sub vectors, backpressure, abuse, reset.
`ifdef MPADD_OVF_DETECT_EN
  `define OVF_ARG(x) , x
`else
  `define OVF_ARG(x)
`endif

module tb_mpadd_seq_112;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_word;
  logic [31:0] b_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s_word;
  logic        out_last;
  logic        carry_out;
  logic        busy;
  logic        done;
`ifdef MPADD_OVF_DETECT_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  mpadd_seq_112 #(.WORDS(4), .IDX_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_word    (s_word),
    .out_last  (out_last),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done)
`ifdef MPADD_OVF_DETECT_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one 4-word operation from IDLE, checking every output word and the completion timing.
  task automatic run_op(input string nm, input logic op, input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] exp_s, input logic exp_c, input int stall, input bit abuse
                        `ifdef MPADD_OVF_DETECT_EN , input logic exp_v `endif);
    logic [31:0] held;
    int ni, no, done_c, first_o, last_o, st_cnt;
    held = '0;
    ni = 0; no = 0; done_c = -1; first_o = -1; last_o = -1; st_cnt = 0;
    @(negedge clk);
    start = 1'b1; sub = op;
    @(negedge clk);
    start = 1'b0; sub = 1'b0;
    chk({nm, " busy"}, 64'(busy), 64'(1));
    for (int cyc = 0; cyc < 40 && done_c < 0; cyc++) begin
      in_valid = (ni < 4);
      a_word   = (ni < 4) ? 32'(a >> (32 * ni)) : 32'h0;
      b_word   = (ni < 4) ? 32'(b >> (32 * ni)) : 32'h0;
      start    = abuse && (cyc == 1);
      sub      = abuse && (cyc == 1) ? !op : 1'b0;
      if (out_valid && st_cnt < stall) begin
        out_ready = 1'b0;
        if (st_cnt == 0) held = s_word;
        else             chk({nm, " stall_hold"}, 64'(s_word), 64'(held));
        st_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (!out_ready) begin
        chk({nm, " stall_in_ready"}, 64'(in_ready), 64'(0));
        chk({nm, " stall_valid"}, 64'(out_valid), 64'(1));
      end
      if (done) begin
        done_c = cyc;
      end else begin
        if (out_valid && out_ready) begin
          if (no < 4) begin
            chk($sformatf("%s word%0d", nm, no), 64'(s_word), 64'(exp_s[32*no +: 32]));
            chk($sformatf("%s last%0d", nm, no), 64'(out_last), 64'(no == 3));
          end
          if (out_last) begin
            chk({nm, " carry_out"}, 64'(carry_out), 64'(exp_c));
`ifdef MPADD_OVF_DETECT_EN
            chk({nm, " ovf"}, 64'(ovf), 64'(exp_v));
`endif
            last_o = cyc;
          end
          if (first_o < 0) first_o = cyc;
          no++;
        end
        if (in_valid && in_ready) ni++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0; sub = 1'b0; out_ready = 1'b1;
    chk({nm, " done_seen"}, 64'(done_c >= 0), 64'(1));
    chk({nm, " n_words"}, 64'(no), 64'(4));
    chk({nm, " done_lat"}, 64'(done_c - last_o), 64'(1));
    if (stall == 0) chk({nm, " throughput"}, 64'(last_o - first_o), 64'(3));
    #1;
    chk({nm, " done_pulse"}, 64'(done), 64'(0));
    chk({nm, " idle"}, 64'(busy), 64'(0));
    chk({nm, " cout_hold"}, 64'(carry_out), 64'(exp_c));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; in_valid = 1'b0;
    a_word = '0; b_word = '0; out_ready = 1'b1;
    #12;
    chk("reset_outs", 64'({in_ready, out_valid, s_word, out_last, carry_out, busy, done}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // All-ones plus one: carry ripples across every word.
    run_op("add_ones", 1'b0, {4{32'hFFFF_FFFF}}, 128'h1, 128'h0, 1'b1, 0, 1'b0 `OVF_ARG(1'b0));
    // 0 - 1: all-ones result with a borrow.
    run_op("sub_0m1", 1'b1, 128'h0, 128'h1, {4{32'hFFFF_FFFF}}, 1'b0, 0, 1'b0 `OVF_ARG(1'b0));
    // Largest positive doubled: signed overflow, no unsigned carry.
    run_op("add_ovf", 1'b0, {32'h7FFF_FFFF, {3{32'hFFFF_FFFF}}}, {32'h7FFF_FFFF, {3{32'hFFFF_FFFF}}},
           {{3{32'hFFFF_FFFF}}, 32'hFFFF_FFFE}, 1'b0, 0, 1'b0 `OVF_ARG(1'b1));
    // Mixed pattern, free-running then with 3 cycles of backpressure.
    run_op("add_mix", 1'b0, 128'h00000001_80000000_FFFFFFFF_12345678,
           128'h00000002_80000000_00000001_EDCBA988,
           128'h00000004_00000001_00000001_00000000, 1'b0, 0, 1'b0 `OVF_ARG(1'b0));
    run_op("add_bp", 1'b0, 128'h00000001_80000000_FFFFFFFF_12345678,
           128'h00000002_80000000_00000001_EDCBA988,
           128'h00000004_00000001_00000001_00000000, 1'b0, 3, 1'b0 `OVF_ARG(1'b0));
    // 5 - 3 with a stray start (and flipped sub) during RUN.
    run_op("sub_abuse", 1'b1, 128'h5, 128'h3, 128'h2, 1'b1, 0, 1'b1 `OVF_ARG(1'b0));

    // in_valid while IDLE must be ignored.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; a_word = 32'h1234_5678; b_word = 32'h1;
      #1;
      chk($sformatf("idle_in%0d", k), 64'({in_ready, out_valid, busy, done}), 64'(0));
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("idle_after_abuse", 64'({out_valid, busy}), 64'(0));

    // Reset after two words have been accepted.
    @(negedge clk);
    start = 1'b1; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; a_word = 32'hAAAA_0001; b_word = 32'h1111_0001;
    @(negedge clk);
    a_word = 32'h5555_0002; b_word = 32'h2222_0002;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_reset_word", 64'(s_word), 64'(32'h7777_0004));
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", 64'({in_ready, out_valid, s_word, out_last, carry_out, busy, done}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add_1p1", 1'b0, 128'h1, 128'h1, 128'h2, 1'b0, 0, 1'b0 `OVF_ARG(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
